// File: rtl/fft_pkg.sv
// Shared FFT definitions: default widths, reader FSM encoding and the
// bit-reverse helper used by the address generators.
package fft_pkg;

  localparam int unsigned AddrWDefault = 5;
  localparam int unsigned DataWDefault = 32;
  localparam int          MaxAddrW     = 16;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2
  } fft_state_e;

  // Reverses the low `width` bits of val; bits at or above width must be zero.
  function automatic logic [MaxAddrW-1:0] bit_reverse(input logic [MaxAddrW-1:0] val,
                                                      input int unsigned       width);
    logic [MaxAddrW-1:0] rev;
    rev = '0;
    for (int i = 0; i < MaxAddrW; i++) begin
      rev[i] = val[MaxAddrW-1-i];
    end
    return rev >> (MaxAddrW - width);
  endfunction

endpackage

// File: rtl/fft_skid_fifo2.sv
// Two-entry FIFO carrying a sample and its end-of-frame flag, valid/ready on both sides.
// Head outputs read as zero while empty.
module fft_skid_fifo2 #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_last_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_last_o,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] data_q [2];
  logic [DATA_W-1:0] data_d [2];
  logic [1:0]        last_q, last_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              push, pop;

  assign out_valid_o = (count_q != 2'd0);
  assign pop         = out_valid_o & out_ready_i;
  // A full buffer can still take a write when the head leaves in the same cycle.
  assign in_ready_o  = (count_q != 2'd2) | pop;
  assign push        = in_valid_i & in_ready_o;

  assign out_data_o  = out_valid_o ? data_q[rd_ptr_q] : '0;
  assign out_last_o  = out_valid_o ? last_q[rd_ptr_q] : 1'b0;
  assign count_o     = count_q;

  always_comb begin
    data_d   = data_q;
    last_d   = last_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      data_d[wr_ptr_q] = in_data_i;
      last_d[wr_ptr_q] = in_last_i;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      data_q   <= '{default: '0};
      last_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      data_q   <= data_d;
      last_q   <= last_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fft_bitrev_reader.sv
// Reads a finished FFT buffer in bit-reversed address order and streams the
// samples out in natural frequency order over a valid/ready interface.
module fft_bitrev_reader
  import fft_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LastIdx = '1;

  fft_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;
  logic              done_q, done_d;

  logic [1:0]        fifo_count;
  logic              fifo_in_ready;
  logic              pop;
  logic [2:0]        occ;

  assign pop = out_valid & out_ready;
  // Entries that will be held next cycle without a new read: buffer + in-flight - leaving head.
  assign occ = {1'b0, fifo_count} + {2'b0, inflight_q} - {2'b0, pop};

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    done_d          = 1'b0;
    rd_en           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
        end
      end
      StRun: begin
        if (occ < 3'd2) begin
          rd_en           = 1'b1;
          inflight_d      = 1'b1;
          inflight_last_d = (cnt_q == LastIdx);
          cnt_d           = cnt_q + ADDR_W'(1);
          if (cnt_q == LastIdx) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        if (pop && out_last) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign rd_addr = rd_en ? ADDR_W'(bit_reverse(MaxAddrW'(cnt_q), ADDR_W)) : '0;
  assign busy    = (state_q != StIdle);
  assign done    = done_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
    end
  end

  fft_skid_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk_i      (clk),
    .clr_i      (clr),
    .in_valid_i (inflight_q),
    .in_ready_o (fifo_in_ready),
    .in_data_i  (rd_data),
    .in_last_i  (inflight_last_q),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .count_o    (fifo_count)
  );

  // The issue rule reserves a slot for every read, so returning data is never refused.
  a_no_overflow: assert property (@(posedge clk) disable iff (clr) inflight_q |-> fifo_in_ready);

endmodule

// File: tb/tb_fft_bitrev_reader.sv
// Bench for fft_bitrev_reader: an 8-point and a 32-point instance, RAM models,
// and a scoreboard of expected natural-order samples.
module tb_fft_bitrev_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr;
  int   cyc = 0;
  always @(posedge clk) cyc++;

  logic        start3, rd_en3, out_valid3, out_ready3, out_last3, busy3, done3;
  logic [2:0]  rd_addr3;
  logic [31:0] rd_data3, out_data3;
  logic        start5, rd_en5, out_valid5, out_ready5, out_last5, busy5, done5;
  logic [4:0]  rd_addr5;
  logic [31:0] rd_data5, out_data5;

  fft_bitrev_reader #(.ADDR_W(3), .DATA_W(32)) u_dut3 (
    .clk(clk), .clr(clr), .start(start3), .rd_en(rd_en3), .rd_addr(rd_addr3),
    .rd_data(rd_data3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_last(out_last3), .busy(busy3), .done(done3)
  );

  fft_bitrev_reader #(.ADDR_W(5), .DATA_W(32)) u_dut5 (
    .clk(clk), .clr(clr), .start(start5), .rd_en(rd_en5), .rd_addr(rd_addr5),
    .rd_data(rd_data5), .out_valid(out_valid5), .out_ready(out_ready5), .out_data(out_data5),
    .out_last(out_last5), .busy(busy5), .done(done5)
  );

  // Output RAMs: RAM[i] = base + i, one-cycle read latency.
  always @(posedge clk) if (rd_en3) rd_data3 <= 32'h10 + 32'(rd_addr3);
  always @(posedge clk) if (rd_en5) rd_data5 <= 32'h100 + 32'(rd_addr5);

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int unsigned rev(input int unsigned v, input int unsigned w);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < w; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  logic [32:0] exp_q3[$];
  logic [32:0] exp_q5[$];
  int          acc_times3[$];

  function automatic void push_frame3();
    for (int unsigned k = 0; k < 8; k++) exp_q3.push_back({k == 7, 32'h10 + 32'(rev(k, 3))});
  endfunction

  function automatic void push_frame5();
    for (int unsigned k = 0; k < 32; k++) exp_q5.push_back({k == 31, 32'h100 + 32'(rev(k, 5))});
  endfunction

  // Monitor for the 8-point instance.
  int          samples3 = 0, dones3 = 0, outst3 = 0;
  int unsigned rd_idx3 = 0;
  logic        exp_done3 = 1'b0, prev_stall3 = 1'b0, pop3;
  logic [32:0] prev_out3, e3;

  always @(negedge clk) begin
    if (exp_done3 || done3) chk("done3", 64'(done3), 64'(exp_done3));
    exp_done3 = 1'b0;
    if (done3) dones3++;
    if (prev_stall3) begin
      chk("hold_valid3", 64'(out_valid3), 64'(1));
      chk("hold_data3", 64'({out_last3, out_data3}), 64'(prev_out3));
    end
    pop3 = out_valid3 && out_ready3;
    if (rd_en3) begin
      chk("rd_rule3", 64'((outst3 - (pop3 ? 1 : 0)) < 2), 64'(1));
      chk("rd_addr3", 64'(rd_addr3), 64'(rev(rd_idx3 % 8, 3)));
      rd_idx3++;
    end
    if (pop3) begin
      if (exp_q3.size() == 0) begin
        n_checks++;
        $display("FAIL out3: unexpected sample 0x%0h, expected none", out_data3);
      end else begin
        e3 = exp_q3.pop_front();
        chk("out3", 64'({out_last3, out_data3}), 64'(e3));
        if (e3[32]) exp_done3 = 1'b1;
      end
      samples3++;
      acc_times3.push_back(cyc);
    end
    outst3 += (rd_en3 ? 1 : 0) - (pop3 ? 1 : 0);
    prev_stall3 = out_valid3 && !out_ready3;
    prev_out3   = {out_last3, out_data3};
    if (clr) begin
      outst3 = 0; rd_idx3 = 0; exp_done3 = 1'b0; prev_stall3 = 1'b0;
      exp_q3.delete();
    end
  end

  // Monitor for the 32-point instance.
  int          samples5 = 0, dones5 = 0;
  logic [32:0] e5;

  always @(negedge clk) begin
    if (out_valid5 && out_ready5) begin
      if (exp_q5.size() == 0) begin
        n_checks++;
        $display("FAIL out5: unexpected sample 0x%0h, expected none", out_data5);
      end else begin
        e5 = exp_q5.pop_front();
        chk("out5", 64'({out_last5, out_data5}), 64'(e5));
      end
      samples5++;
    end
    if (done5) dones5++;
    if (clr) exp_q5.delete();
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame3();
    start3 = 1'b1;
    push_frame3();
    tick();
    start3 = 1'b0;
  endtask

  task automatic wait_done3(input int mode, input int max_cyc);
    int d0, n;
    d0 = dones3;
    n  = 0;
    while (dones3 == d0 && n < max_cyc) begin
      case (mode)
        0:       out_ready3 = 1'b1;
        1:       out_ready3 = (n % 3 == 0);
        default: out_ready3 = 1'($urandom_range(0, 1));
      endcase
      tick();
      n++;
    end
    out_ready3 = 1'b1;
    if (dones3 == d0) begin
      n_checks++;
      $display("FAIL wait_done3: no done within %0d cycles, expected one", max_cyc);
    end
  endtask

  typedef struct {
    int ready_mode;
    int exp_samples;
    int exp_dones;
    int max_cycles;
    int exp_span;
  } vec_t;

  vec_t vecs[3];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int s0, d0, n;
    vecs[0] = '{0, 8, 1, 40, 7};
    vecs[1] = '{1, 8, 1, 120, -1};
    vecs[2] = '{2, 8, 1, 200, -1};

    clr = 1'b1; start3 = 1'b0; start5 = 1'b0; out_ready3 = 1'b0; out_ready5 = 1'b0;
    repeat (3) tick();
    clr = 1'b0;
    @(negedge clk);
    chk("reset_outs3", 64'({rd_en3, rd_addr3, out_valid3, out_data3, out_last3, busy3, done3}),
        64'(0));
    chk("reset_outs5", 64'({rd_en5, rd_addr5, out_valid5, out_data5, out_last5, busy5, done5}),
        64'(0));
    tick();

    // Latency: rd_en one cycle after start, out_valid three cycles after.
    out_ready3 = 1'b1;
    start3 = 1'b1;
    push_frame3();
    @(negedge clk);
    chk("lat_idle_busy", 64'({busy3, rd_en3}), 64'(0));
    tick();
    start3 = 1'b0;
    @(negedge clk);
    chk("lat_rd_en", 64'({busy3, rd_en3, out_valid3}), 64'(3'b110));
    tick();
    @(negedge clk);
    chk("lat_t2_valid", 64'(out_valid3), 64'(0));
    tick();
    @(negedge clk);
    chk("lat_t3_head", 64'({out_valid3, out_data3}), 64'({1'b1, 32'h10}));
    wait_done3(0, 40);

    // Frames under different consumer ready patterns.
    for (int v = 0; v < 3; v++) begin
      s0 = samples3;
      d0 = dones3;
      acc_times3.delete();
      out_ready3 = 1'b1;
      start_frame3();
      wait_done3(vecs[v].ready_mode, vecs[v].max_cycles);
      chk("tbl_samples", 64'(samples3 - s0), 64'(vecs[v].exp_samples));
      chk("tbl_dones", 64'(dones3 - d0), 64'(vecs[v].exp_dones));
      chk("tbl_empty", 64'(exp_q3.size()), 64'(0));
      if (vecs[v].exp_span >= 0 && acc_times3.size() > 0)
        chk("tbl_span", 64'(acc_times3[$] - acc_times3[0]), 64'(vecs[v].exp_span));
    end

    // Consumer stalled for 10 cycles: only two reads may be issued.
    out_ready3 = 1'b0;
    s0 = rd_idx3;
    start_frame3();
    repeat (10) tick();
    chk("stall_reads", 64'(rd_idx3 - s0), 64'(2));
    @(negedge clk);
    chk("stall_head", 64'({out_valid3, out_last3, out_data3}), 64'({2'b10, 32'h10}));
    wait_done3(0, 40);
    chk("stall_empty", 64'(exp_q3.size()), 64'(0));

    // clr in the cycle of the 4th acceptance aborts the frame.
    s0 = samples3;
    d0 = dones3;
    out_ready3 = 1'b1;
    start_frame3();
    n = 0;
    while (!((samples3 - s0) == 3 && out_valid3) && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      n_checks++;
      $display("FAIL clr_setup: 4th sample not reached, got %0d samples", samples3 - s0);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    chk("clr_outs", 64'({rd_en3, rd_addr3, out_valid3, out_data3, out_last3, busy3, done3}),
        64'(0));
    repeat (5) tick();
    chk("clr_no_done", 64'(dones3 - d0), 64'(0));
    chk("clr_samples", 64'(samples3 - s0), 64'(4));
    start_frame3();
    wait_done3(0, 40);
    chk("clr_restart_empty", 64'(exp_q3.size()), 64'(0));

    // start mid-frame is ignored; start coincident with done is accepted.
    s0 = samples3;
    d0 = dones3;
    start_frame3();
    repeat (4) tick();
    start3 = 1'b1;
    tick();
    start3 = 1'b0;
    n = 0;
    while (!done3 && n < 60) begin
      tick();
      n++;
    end
    if (!done3) begin
      n_checks++;
      $display("FAIL b2b_done: no done within 60 cycles, expected one");
    end else begin
      start3 = 1'b1;
      push_frame3();
      tick();
      start3 = 1'b0;
      @(negedge clk);
      chk("b2b_busy", 64'(busy3), 64'(1));
    end
    wait_done3(0, 60);
    chk("b2b_dones", 64'(dones3 - d0), 64'(2));
    chk("b2b_samples", 64'(samples3 - s0), 64'(16));
    chk("b2b_empty", 64'(exp_q3.size()), 64'(0));

    // 32-point frame, consumer always ready; busy must stay high until done.
    out_ready5 = 1'b1;
    start5 = 1'b1;
    push_frame5();
    tick();
    start5 = 1'b0;
    n = 0;
    forever begin
      @(negedge clk);
      if (done5 || n >= 80) break;
      chk("busy5", 64'(busy5), 64'(1));
      @(posedge clk);
      #1;
      n++;
    end
    if (!done5) begin
      n_checks++;
      $display("FAIL wait_done5: no done within 80 cycles, expected one");
    end
    chk("done5_busy_low", 64'(busy5), 64'(0));
    tick();
    chk("n32_samples", 64'(samples5), 64'(32));
    chk("n32_dones", 64'(dones5), 64'(1));
    chk("n32_empty", 64'(exp_q5.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reader.md
Name: fft_bitrev_reader

Overview:
- Reads a completed FFT result buffer in bit-reversed address order and streams samples out in natural frequency order.
- Uses a valid/ready handshake on the output.
- Read side of the FFT output memory; the write side fills that memory with a natural-order up-counter.
- Sits between the output RAM (synchronous read, 1-cycle latency) and the downstream sample consumer.

Parameters:
- ADDR_W, 5, address width; frame length N = 2^ADDR_W points.
- DATA_W, 32, sample width (packed real/imag).

Ports:
- clk  in  1  clock, all logic on posedge.
- clr  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse: begin reading one frame; ignored unless idle.
- rd_en  out  1  RAM read enable.
- rd_addr  out  ADDR_W  RAM read address, bit-reversed frame index.
- rd_data  in  DATA_W  RAM read data, valid the cycle after rd_en.
- out_valid  out  1  output sample valid.
- out_ready  in  1  consumer accepts when out_valid & out_ready.
- out_data  out  DATA_W  output sample.
- out_last  out  1  high with the final (index N-1) sample of a frame.
- busy  out  1  high from the cycle after an accepted start until the last sample is accepted.
- done  out  1  one-cycle pulse the cycle after the last sample is accepted.

Behaviour:
- Reset (clr=1 at posedge): state IDLE; index counter 0; buffer empty; in-flight flag 0.
  - Outputs after reset: rd_en=0, rd_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0.
  - clr mid-frame aborts the frame immediately: no done pulse, in-flight read data discarded.
- FSM states:
  - IDLE: on start go to RUN, counter=0.
  - RUN: issue reads; after the read of index N-1 is issued, go to DRAIN.
  - DRAIN: wait for the buffer and in-flight read to empty; when the last sample is accepted, go to IDLE and pulse done.
- Address: rd_addr = bit-reverse(counter) over ADDR_W bits, combinational from the counter, gated to 0 when rd_en=0.
- Counter: increments by 1 on each issued read. Its wrap from N-1 to 0 coincides with entering DRAIN and is not reused in that frame.
- Output buffer:
  - 2-entry FIFO; data written the cycle after rd_en; out_data/out_valid driven from the head entry.
  - The last flag is stored per entry, set for index N-1.
- Read issue rule: rd_en=1 in RUN iff (buffer occupancy + in-flight) < 2, counting a pop in the same cycle.
  - Result: with out_ready held high, steady state is 1 sample/cycle.
- Latency: start at cycle t → rd_en at t+1 → out_valid at t+3 (registered FIFO head).
- Backpressure: while out_ready=0, out_data/out_valid/out_last hold stable; no sample is dropped or duplicated.
- Simultaneous push and pop on the buffer: occupancy unchanged; ordering preserved.
- start while busy: ignored, no effect on the frame in progress.
- start in the same cycle as done: accepted; the new frame starts.
- done pulses exactly once per completed frame.
- clr has priority over start.

Decomposition:
- Shared package fft_pkg: ADDR_W/DATA_W defaults, FSM state encoding (IDLE, RUN, DRAIN), and a bit-reverse function.
  - The same function is reused by the other address generators.
- One natural sub-module: fft_skid_fifo2, the 2-entry FIFO with data and last-flag storage, valid/ready on both sides.
- Counter and FSM stay inline.

Test Plan:
- ADDR_W=3, RAM[i]=0x10+i, out_ready=1, start pulse → rd_addr sequence 0,4,2,6,1,5,3,7.
  - out_data sequence 0x10,0x14,0x12,0x16,0x11,0x15,0x13,0x17 on 8 consecutive cycles.
  - out_last only on 0x17; done one cycle after that acceptance.
- Same setup, out_ready toggling 1,0,0,1,... → identical 8-value sequence.
  - out_data stable during stalls; rd_en never issued with occupancy+in-flight=2.
- out_ready=0 for 10 cycles after start → exactly 2 reads issued (addr 0,4); out_valid=1 holding 0x10.
  - After ready rises, the full sequence completes with no loss.
- clr asserted on the 4th accepted sample → next cycle all outputs 0, busy=0, no done pulse.
  - A later start produces the full sequence from 0x10.
- start pulsed again mid-frame → ignored; exactly 8 samples and one done.
  - Then start coincident with done → a second frame of 8 samples follows.
- ADDR_W=5 frame with out_ready high → 32 samples in bit-reversed index order; out_last on index 31; busy high for the whole frame.
